// File: rtl/fpga_serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. A single majority carry cell is
// time-shared across all WIDTH bit positions, stepping LSB first, one bit
// per cycle. Operands arrive and results leave over valid/ready handshakes.
module fpga_serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  input  logic             abort_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             carry_msb;

  logic             sum_bit, carry_nxt, at_msb_m1, at_last;
  logic [WIDTH-1:0] sum_nxt;

  // Shared carry cell plus the bit-position decodes that steer it.
  always_comb begin
    sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 lands at 0.
    sum_nxt   = (sum_sr >> 1) | ({{(WIDTH-1){1'b0}}, sum_bit} << (WIDTH-1));
    at_msb_m1 = (cnt == CNT_W'(WIDTH-2));
    at_last   = (cnt == CNT_W'(WIDTH-1));
  end

  // Control FSM and datapath; result registers only change on completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      sum_o     <= '0;
      cout_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort_i has no effect here; an accept proceeds regardless.
          if (in_valid_i) begin
            a_sr  <= a_i;
            b_sr  <= sub_i ? ~b_i : b_i;
            carry <= sub_i ? 1'b1 : cin_i;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            // Partial result dropped; visible result registers untouched.
            cnt   <= '0;
            state <= IDLE;
          end else begin
            sum_sr <= sum_nxt;
            carry  <= carry_nxt;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            if (at_msb_m1) carry_msb <= carry_nxt;
            if (at_last) begin
              sum_o  <= sum_nxt;
              cout_o <= carry_nxt;
              ovf_o  <= carry_msb ^ carry_nxt;
              cnt    <= '0;
              state  <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state == RUN);
  assign out_valid_o = (state == DONE);

endmodule

// File: tb/tb_fpga_serial_add_ctrl.sv
// Directed bench for the bit-serial adder: table of hand-computed vectors
// plus sequences for backpressure, abort and asynchronous reset.
module tb_fpga_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, abort_s;
  logic [W-1:0] a, b, sum;
  logic         out_valid, out_ready, cout, ovf, busy;

  int errors = 0;
  int checks = 0;

  fpga_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .abort_i(abort_s),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] sum;
    logic         cout, ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive operands at a negedge; accept happens on the following posedge.
  task automatic start_op(input logic [W-1:0] ta, tb, input logic tc, ts);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge right after the accept edge; returns cycles seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("result_latency", lat, W);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    start_op(v.a, v.b, v.cin, v.sub);
    chk({name, "_busy"}, busy, 1);
    wait_valid(lat);
    chk({name, "_sum"}, sum, v.sum);
    chk({name, "_cout"}, cout, v.cout);
    chk({name, "_ovf"}, ovf, v.ovf);
    @(negedge clk);  // out_ready high: handshake on the intervening edge
    chk({name, "_idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    logic [W-1:0] held;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};  // cin ignored on sub
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0;
    abort_s = 0; out_ready = 1'b1;
    #12;
    chk("reset_outputs", {in_ready, out_valid, busy, cout, ovf, sum}, {1'b1, 4'b0, 8'h00});
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result holds for 5 cycles, new requests are ignored.
    out_ready = 1'b0;
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_valid(lat);
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, busy, sum, cout, ovf}, {3'b100, 8'h96, 2'b01});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", {out_valid, in_ready, sum}, {2'b01, 8'h96});

    // Abort three cycles into RUN, then an immediate new operation.
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    chk("abort_idle", {busy, in_ready, out_valid, sum}, {3'b010, 8'h96});
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    run_vec(vecs[2], "post_abort");

    // Asynchronous reset mid-RUN, off the clock edge.
    start_op(8'h33, 8'h44, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {in_ready, out_valid, busy, cout, ovf, sum}, {1'b1, 4'b0, 8'h00});
    held = sum;
    @(negedge clk);
    chk("reset_held", {out_valid, held}, {1'b0, 8'h00});
    rst_n = 1'b1;

    // Back-to-back operations with the consumer always ready.
    run_vec(vecs[0], "b2b0");
    run_vec(vecs[3], "b2b1");
    run_vec(vecs[1], "b2b2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
